mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multicycle control unit for the RV32I datapath: the sequencing end of the ALU interface. It decodes opcode/funct fields from the external instruction register, steps a Moore FSM through fetch/decode/execute/memory/writeback, and drives the ALU operation code, operand selects, result select and all write strobes. It consumes the ALU `zero` flag to resolve branches and handshakes with a single shared instruction/data memory port.

## Interface
- No parameters.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 7: `instr[6:0]` from IR.
- `funct3` in 3: `instr[14:12]`.
- `funct7b5` in 1: `instr[30]`.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access requested.
- `ALUcontrol` out 4: AND=0000, OR=0001, ADD=0010, SUB=0110.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 regA.
- `ALUSrcB` out 2: 00 regB, 01 ImmExt, 10 constant 4.
- `ResultSrc` out 2: 00 ALUOut reg, 01 Data reg, 10 alu_out direct.
- `ImmSrc` out 2: 00 I, 01 S, 10 B, 11 J.
- `AdrSrc` out 1: 0 PC, 1 Result.
- `IRWrite`, `PCWrite`, `RegWrite`, `MemWrite` out 1 each: write strobes.
- `illegal` out 1: sticky illegal-instruction flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, ILLEGAL. Encoding is free; state is registered and outputs are decoded from state, plus `mem_ready`/`zero` where noted.
- FETCH: `mem_req`=1, AdrSrc=0, A=PC, B=4, ADD, ResultSrc=10, `IRWrite`=`PCWrite`=`mem_ready`. Stay until `mem_ready`, then go to DECODE.
- DECODE: A=OldPC, B=Imm, ADD (branch target into ALUOut), and ImmSrc from op. Next state by op:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - otherwise → ILLEGAL
- MEMADR: A=regA, B=Imm, ADD. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00, `mem_req`=1. Wait for `mem_ready`, then MEMWB.
- MEMWB: ResultSrc=01, `RegWrite`=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, `mem_req`=1, `MemWrite`=`mem_ready`. On `mem_ready` go to FETCH.
- EXECR/EXECI: A=regA, B=regB (EXECR) or Imm (EXECI); ALUcontrol from the funct decode below; then ALUWB.
- Funct decode:
  - funct3 000: SUB iff EXECR and funct7b5=1, else ADD.
  - funct3 110: OR.
  - funct3 111: AND.
  - Any other funct3 in DECODE for an R/I op → ILLEGAL, with no writeback.
- ALUWB: ResultSrc=00, `RegWrite`=1, then FETCH.
- BEQ: A=regA, B=regB, SUB, ResultSrc=00, `PCWrite`=`zero`; only funct3=000 is legal. Then FETCH.
- JAL: A=OldPC, B=4, ADD, ResultSrc=00, `PCWrite`=1; then ALUWB.
- ILLEGAL: all strobes 0 and `illegal`=1. Absorbing; leaves only on reset.
- In every state, any select not listed is don't-care and is driven as 0.

## Timing
- Reset (`rst_n` low, asynchronous): state=FETCH.
  - `IRWrite`, `PCWrite`, `RegWrite`, `MemWrite`, `mem_req`, `illegal` all 0 while reset is held.
  - All other outputs take their FETCH values.
- Reset mid-instruction aborts it; no strobe is emitted after `rst_n` falls.
- Cycles per instruction with `mem_ready` held 1: R/I 4, lw 5, sw 4, beq 3, jal 4. Each wait cycle adds 1 in FETCH, MEMREAD or MEMWRITE.
- `mem_req` stays high and outputs stay stable for as long as `mem_ready` is 0.
- `PCWrite` in BEQ is combinational on `zero` in the same cycle.

## Configuration
- `MC_CTRL_BNE_EN` defined: op 1100011 with funct3=001 is accepted; `PCWrite`=~`zero` in the branch state.
- `MC_CTRL_BNE_EN` not defined: funct3=001 → ILLEGAL.

## Test plan
- Reset, then `mem_ready`=1 and `add x3,x1,x2` (op 0110011, f3 000, f7b5 0) → states FETCH, DECODE, EXECR, ALUWB; ALUcontrol=0010 in EXECR; `RegWrite`=1 exactly in cycle 4.
- `sub` (f7b5=1) → ALUcontrol=0110 in EXECR. `addi` with f7b5=1 → 0010. `ori` → 0001. `andi` → 0111 decodes as AND=0000.
- lw with `mem_ready` low for 3 cycles in MEMREAD → 8 cycles total; `mem_req` held; `RegWrite` with ResultSrc=01 in the last cycle.
- sw → `MemWrite` pulses 1 cycle, coincident with `mem_ready`. beq with `zero`=1 → `PCWrite`=1 in cycle 3; with `zero`=0 → no `PCWrite`.
- op 1111111 → ILLEGAL; `illegal`=1 and all strobes 0 for 20 cycles; `rst_n` pulse returns to FETCH with `illegal`=0.
- `rst_n` asserted in MEMWRITE with `mem_ready`=1 → `MemWrite` drops immediately (asynchronously). With/without `MC_CTRL_BNE_EN`: bne takes the branch / goes to ILLEGAL.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control-side bundle between the RV32I multicycle sequencer and its datapath/memory.
// Latency: none, wires only.
// Backpressure: mem_ready from the shared memory port stalls the sequencer while mem_req is high.
interface mc_control_fsm_if;
    // Instruction fields from IR, ALU flag and memory handshake
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    // Datapath controls and strobes
    logic       mem_req;
    logic [3:0] ALUcontrol;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       illegal;

    // Sequencer side
    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output mem_req, ALUcontrol, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
               AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal
    );

    // Datapath / memory side
    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  mem_req, ALUcontrol, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
               AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Moore sequencer for the RV32I multicycle datapath (fetch/decode/execute/mem/writeback).
// Latency: R/I 4, lw 5, sw 4, beq 3, jal 4 cycles with mem_ready high; +1 per memory wait cycle.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold with mem_req high until mem_ready. Option macro: MC_CTRL_BNE_EN adds bne.
module mc_control_fsm (
    input  logic              clk,
    input  logic              rst_n,
    mc_control_fsm_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [1:0] A_PC    = 2'b00;
    localparam logic [1:0] A_OLDPC = 2'b01;
    localparam logic [1:0] A_REGA  = 2'b10;
    localparam logic [1:0] B_REGB  = 2'b00;
    localparam logic [1:0] B_IMM   = 2'b01;
    localparam logic [1:0] B_FOUR  = 2'b10;
    localparam logic [1:0] R_ALUOUT = 2'b00;
    localparam logic [1:0] R_DATA   = 2'b01;
    localparam logic [1:0] R_DIRECT = 2'b10;

    state_t     state;
    state_t     state_nxt;
    logic       funct_ok;
    logic       branch_ok;
    logic       branch_taken;
    logic [1:0] imm_sel;
    logic [3:0] alu_funct;

    // Field decodes shared by next-state and output logic
    always_comb begin
        funct_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
`ifdef MC_CTRL_BNE_EN
        branch_ok    = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);
        branch_taken = bus.funct3[0] ? ~bus.zero : bus.zero;
`else
        branch_ok    = (bus.funct3 == 3'b000);
        branch_taken = bus.zero;
`endif
        case (bus.op)
            OP_SW:   imm_sel = 2'b01;
            OP_BR:   imm_sel = 2'b10;
            OP_JAL:  imm_sel = 2'b11;
            default: imm_sel = 2'b00;
        endcase
        // SUB only for register-register with instr[30] set; addi ignores bit 30
        case (bus.funct3)
            3'b000:  alu_funct = (state == S_EXECR && bus.funct7b5) ? ALU_SUB : ALU_ADD;
            3'b110:  alu_funct = ALU_OR;
            3'b111:  alu_funct = ALU_AND;
            default: alu_funct = ALU_ADD;
        endcase
    end

    // State register; reset lands in FETCH and aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    if (bus.mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = funct_ok  ? S_EXECR : S_ILLEGAL;
                    OP_I:         state_nxt = funct_ok  ? S_EXECI : S_ILLEGAL;
                    OP_BR:        state_nxt = branch_ok ? S_BEQ   : S_ILLEGAL;
                    OP_JAL:       state_nxt = S_JAL;
                    default:      state_nxt = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_nxt = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_nxt = S_MEMWB;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state_nxt = S_FETCH;
            S_EXECR:    state_nxt = S_ALUWB;
            S_EXECI:    state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BEQ:      state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
            S_ILLEGAL:  state_nxt = S_ILLEGAL;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // Output decode from state; strobes are forced low while reset is asserted
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.ALUcontrol = ALU_AND;
        bus.ALUSrcA    = A_PC;
        bus.ALUSrcB    = B_REGB;
        bus.ResultSrc  = R_ALUOUT;
        bus.ImmSrc     = 2'b00;
        bus.AdrSrc     = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_req    = 1'b1;
                bus.ALUcontrol = ALU_ADD;
                bus.ALUSrcB    = B_FOUR;
                bus.ResultSrc  = R_DIRECT;
                bus.IRWrite    = bus.mem_ready;
                bus.PCWrite    = bus.mem_ready;
            end
            S_DECODE: begin
                bus.ALUcontrol = ALU_ADD;
                bus.ALUSrcA    = A_OLDPC;
                bus.ALUSrcB    = B_IMM;
                bus.ImmSrc     = imm_sel;
            end
            S_MEMADR: begin
                // stores need the S-type immediate for the address add
                bus.ALUcontrol = ALU_ADD;
                bus.ALUSrcA    = A_REGA;
                bus.ALUSrcB    = B_IMM;
                bus.ImmSrc     = imm_sel;
            end
            S_MEMREAD: begin
                bus.mem_req = 1'b1;
                bus.AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                bus.ResultSrc = R_DATA;
                bus.RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.mem_req  = 1'b1;
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = bus.mem_ready;
            end
            S_EXECR: begin
                bus.ALUcontrol = alu_funct;
                bus.ALUSrcA    = A_REGA;
                bus.ALUSrcB    = B_REGB;
            end
            S_EXECI: begin
                bus.ALUcontrol = alu_funct;
                bus.ALUSrcA    = A_REGA;
                bus.ALUSrcB    = B_IMM;
            end
            S_ALUWB: begin
                bus.RegWrite = 1'b1;
            end
            S_BEQ: begin
                bus.ALUcontrol = ALU_SUB;
                bus.ALUSrcA    = A_REGA;
                bus.ALUSrcB    = B_REGB;
                bus.PCWrite    = branch_taken;
            end
            S_JAL: begin
                // ALUOut still holds the target from DECODE; ALU makes the link value
                bus.ALUcontrol = ALU_ADD;
                bus.ALUSrcA    = A_OLDPC;
                bus.ALUSrcB    = B_FOUR;
                bus.PCWrite    = 1'b1;
            end
            S_ILLEGAL: begin
                bus.illegal = 1'b1;
            end
            default: begin
            end
        endcase
        if (!rst_n) begin
            bus.mem_req  = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.PCWrite  = 1'b0;
            bus.RegWrite = 1'b0;
            bus.MemWrite = 1'b0;
            bus.illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: checks the full control word every cycle of each instruction.
// Inputs change at the falling edge; outputs are checked at the falling edge (or 1ns after an input change).
module tb_mc_control_fsm;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mc_control_fsm_if bus();

    mc_control_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;

    // {mem_req, ALUcontrol, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal}
    logic [18:0] obs;
    assign obs = {bus.mem_req, bus.ALUcontrol, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc,
                  bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.illegal};

    function automatic logic [18:0] v(input logic mr, input logic [3:0] alu, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] rs, input logic [1:0] imm,
                                      input logic adr, input logic irw, input logic pcw,
                                      input logic rw, input logic mw, input logic ill);
        return {mr, alu, a, b, rs, imm, adr, irw, pcw, rw, mw, ill};
    endfunction

    // Expected control words per state
    function automatic logic [18:0] e_fetch(input logic rdy);
        return v(1, A_ADD, 2'd0, 2'd2, 2'd2, 2'd0, 0, rdy, rdy, 0, 0, 0);
    endfunction
    function automatic logic [18:0] e_rst();
        return v(0, A_ADD, 2'd0, 2'd2, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [18:0] e_dec(input logic [1:0] imm);
        return v(0, A_ADD, 2'd1, 2'd1, 2'd0, imm, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [18:0] e_exr(input logic [3:0] alu);
        return v(0, alu, 2'd2, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [18:0] e_exi(input logic [3:0] alu);
        return v(0, alu, 2'd2, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [18:0] e_aluwb();
        return v(0, A_AND, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0);
    endfunction
    function automatic logic [18:0] e_memadr(input logic [1:0] imm);
        return v(0, A_ADD, 2'd2, 2'd1, 2'd0, imm, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [18:0] e_memrd();
        return v(1, A_AND, 2'd0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [18:0] e_memwb();
        return v(0, A_AND, 2'd0, 2'd0, 2'd1, 2'd0, 0, 0, 0, 1, 0, 0);
    endfunction
    function automatic logic [18:0] e_memwr(input logic mw);
        return v(1, A_AND, 2'd0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, mw, 0);
    endfunction
    function automatic logic [18:0] e_br(input logic pcw);
        return v(0, A_SUB, 2'd2, 2'd0, 2'd0, 2'd0, 0, 0, pcw, 0, 0, 0);
    endfunction
    function automatic logic [18:0] e_jal();
        return v(0, A_ADD, 2'd1, 2'd2, 2'd0, 2'd0, 0, 0, 1, 0, 0, 0);
    endfunction
    function automatic logic [18:0] e_ill();
        return v(0, A_AND, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1);
    endfunction

    task automatic chk(input string tag, input logic [18:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, expv);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        bus.op = o;
        bus.funct3 = f3;
        bus.funct7b5 = f7;
    endtask

    // Starts and ends at a falling edge with the DUT in FETCH and mem_ready=1
    task automatic alu_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic [18:0] exec_exp);
        set_instr(o, f3, f7);
        #1 chk({tag, "_fetch"}, e_fetch(1'b1));
        nxt(); chk({tag, "_decode"}, e_dec(2'd0));
        nxt(); chk({tag, "_exec"}, exec_exp);
        nxt(); chk({tag, "_wb"}, e_aluwb());
        nxt();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1 chk("rst_pulse", e_rst());
        nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        bus.zero = 1'b0;
        set_instr(7'd0, 3'd0, 1'b0);
        nxt(); nxt();
        chk("rst_hold", e_rst());
        bus.mem_ready = 1'b1;
        #1 chk("rst_hold_rdy", e_rst());
        nxt();
        rst_n = 1'b1;

        // R/I arithmetic
        alu_instr("add",  7'b0110011, 3'b000, 1'b0, e_exr(A_ADD));
        alu_instr("sub",  7'b0110011, 3'b000, 1'b1, e_exr(A_SUB));
        alu_instr("addi", 7'b0010011, 3'b000, 1'b1, e_exi(A_ADD));
        alu_instr("ori",  7'b0010011, 3'b110, 1'b0, e_exi(A_OR));
        alu_instr("andi", 7'b0010011, 3'b111, 1'b0, e_exi(A_AND));
        alu_instr("or",   7'b0110011, 3'b110, 1'b0, e_exr(A_OR));

        // fetch wait: one stalled cycle keeps mem_req and drops strobes
        set_instr(7'b0110011, 3'b111, 1'b0);
        bus.mem_ready = 1'b0;
        #1 chk("fetch_wait", e_fetch(1'b0));
        nxt(); chk("fetch_wait2", e_fetch(1'b0));
        bus.mem_ready = 1'b1;
        #1 chk("fetch_go", e_fetch(1'b1));
        nxt(); chk("and_decode", e_dec(2'd0));
        nxt(); chk("and_exec", e_exr(A_AND));
        nxt(); chk("and_wb", e_aluwb());
        nxt();

        // lw with three wait cycles in MEMREAD: 8 cycles total
        set_instr(7'b0000011, 3'b010, 1'b0);
        #1 chk("lw_fetch", e_fetch(1'b1));
        nxt(); chk("lw_decode", e_dec(2'd0));
        bus.mem_ready = 1'b0;
        nxt(); chk("lw_memadr", e_memadr(2'd0));
        nxt(); chk("lw_wait1", e_memrd());
        nxt(); chk("lw_wait2", e_memrd());
        nxt(); chk("lw_wait3", e_memrd());
        nxt(); bus.mem_ready = 1'b1;
        #1 chk("lw_ready", e_memrd());
        nxt(); chk("lw_memwb", e_memwb());
        nxt();

        // sw with one wait cycle; MemWrite only when mem_ready
        set_instr(7'b0100011, 3'b010, 1'b0);
        #1 chk("sw_fetch", e_fetch(1'b1));
        nxt(); chk("sw_decode", e_dec(2'd1));
        bus.mem_ready = 1'b0;
        nxt(); chk("sw_memadr", e_memadr(2'd1));
        nxt(); chk("sw_wait", e_memwr(1'b0));
        bus.mem_ready = 1'b1;
        #1 chk("sw_write", e_memwr(1'b1));
        nxt(); chk("sw_next_fetch", e_fetch(1'b1));

        // beq taken, then not taken with a same-cycle zero change
        set_instr(7'b1100011, 3'b000, 1'b0);
        bus.zero = 1'b1;
        nxt(); chk("beq_decode", e_dec(2'd2));
        nxt(); chk("beq_taken", e_br(1'b1));
        nxt(); chk("beq_next_fetch", e_fetch(1'b1));
        bus.zero = 1'b0;
        nxt(); chk("beq2_decode", e_dec(2'd2));
        nxt(); chk("beq_not_taken", e_br(1'b0));
        bus.zero = 1'b1;
        #1 chk("beq_zero_comb", e_br(1'b1));
        bus.zero = 1'b0;
        nxt();

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        #1 chk("jal_fetch", e_fetch(1'b1));
        nxt(); chk("jal_decode", e_dec(2'd3));
        nxt(); chk("jal_exec", e_jal());
        nxt(); chk("jal_wb", e_aluwb());
        nxt();

        // reset during MEMWRITE with mem_ready high kills MemWrite at once
        set_instr(7'b0100011, 3'b010, 1'b0);
        nxt(); nxt(); chk("swr_memadr", e_memadr(2'd1));
        nxt(); chk("swr_write", e_memwr(1'b1));
        rst_n = 1'b0;
        #1 chk("swr_reset_async", e_rst());
        nxt(); rst_n = 1'b1;

        // undefined opcode: absorbing ILLEGAL
        set_instr(7'b1111111, 3'b000, 1'b0);
        #1 chk("ill_fetch", e_fetch(1'b1));
        nxt(); chk("ill_decode", e_dec(2'd0));
        for (int i = 0; i < 20; i++) begin
            nxt();
            bus.mem_ready = i[0];
            bus.zero = i[1];
            set_instr(7'b0110011, 3'b000, 1'b0);
            #1 chk($sformatf("ill_hold%0d", i), e_ill());
        end
        bus.mem_ready = 1'b1;
        bus.zero = 1'b0;
        reset_pulse();
        alu_instr("post_ill_add", 7'b0110011, 3'b000, 1'b0, e_exr(A_ADD));

        // R-type with unsupported funct3 goes illegal without writeback
        set_instr(7'b0110011, 3'b001, 1'b0);
        nxt(); chk("badf3_decode", e_dec(2'd0));
        nxt(); chk("badf3_ill", e_ill());
        nxt(); chk("badf3_ill2", e_ill());
        reset_pulse();

        // beq with funct3=001 (bne) depends on build option
        set_instr(7'b1100011, 3'b001, 1'b0);
        bus.zero = 1'b0;
        nxt(); chk("bne_decode", e_dec(2'd2));
        nxt();
`ifdef MC_CTRL_BNE_EN
        chk("bne_taken", e_br(1'b1));
        bus.zero = 1'b1;
        #1 chk("bne_not_taken", e_br(1'b0));
        nxt(); chk("bne_next_fetch", e_fetch(1'b1));
`else
        chk("bne_illegal", e_ill());
        nxt(); chk("bne_illegal2", e_ill());
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
